fdt_scheduler: RTL

Schedules the PICC response for the ISO/IEC 14443-2 Type A PICC. It sits between the PCD→PICC receive path (pause detector plus sequence decoder on the rx bit interface) and the PICC→PCD transmit encoder. The block timestamps the last PCD pause and remembers the last received data bit. It then releases a pending transmit request only on a legal frame delay time (FDT) slot: n·128 + 84 ticks after a final '1', n·128 + 20 ticks after a final '0', with n ≥ 9.

---
 rtl/ISO14443A_pkg.sv | 20 ++
 rtl/pause_edge_detect.sv | 24 ++
 rtl/fdt_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ISO14443A_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ISO/IEC 14443-2 Type A shared constants and types.
package ISO14443A_pkg;

  localparam int unsigned BIT_PERIOD = 128;
  localparam int unsigned FDT_BASE_0 = 9 * BIT_PERIOD + 20;
  localparam int unsigned FDT_BASE_1 = 9 * BIT_PERIOD + 84;
  localparam int unsigned FDT_CNT_W  = 11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX       = 3'd1,
    FDT_WAIT = 3'd2,
    SLOT     = 3'd3,
    TX       = 3'd4
  } FDTState;

endpackage
`default_nettype wire

// File: rtl/pause_edge_detect.sv
`timescale 1ns/1ps
`default_nettype none
// Detects the end of a PCD pause: synchronised pause_n going from 0 to 1.
module pause_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_n_synchronised,
  output logic pause_end
);

  logic pause_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_n_q <= 1'b1;
    end else begin
      pause_n_q <= pause_n_synchronised;
    end
  end

  assign pause_end = ~pause_n_q & pause_n_synchronised;

endmodule
`default_nettype wire

// File: rtl/fdt_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// Releases a pending PICC response only on a legal frame delay time slot
// measured from the last PCD pause end.
module fdt_scheduler #(
  parameter int unsigned FDT_BASE_0 = ISO14443A_pkg::FDT_BASE_0,
  parameter int unsigned FDT_BASE_1 = ISO14443A_pkg::FDT_BASE_1,
  parameter int unsigned TX_LATENCY = 3,
  parameter int unsigned PAUSE_COMP = 0,
  parameter int unsigned MAX_SLOTS  = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_n_synchronised,
  input  logic rx_soc,
  input  logic rx_eoc,
  input  logic rx_error,
  input  logic rx_data_valid,
  input  logic rx_data,
  input  logic tx_req,
  input  logic tx_done,
  output logic tx_start,
  output logic tx_active,
  output logic window_missed
);

  import ISO14443A_pkg::*;

  localparam int unsigned CW = FDT_CNT_W;
  localparam int unsigned PW = $clog2(BIT_PERIOD);
  localparam int unsigned SW = $clog2(MAX_SLOTS + 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] TARGET_0   = CW'(FDT_BASE_0 - TX_LATENCY);
  localparam logic [CW-1:0] TARGET_1   = CW'(FDT_BASE_1 - TX_LATENCY);
  localparam logic [CW-1:0] PRELOAD    = CW'(PAUSE_COMP + 1);
  localparam logic [CW-1:0] SLOT_LEAD  = CW'(2);
  localparam logic [SW-1:0] SLOTS_LAST = SW'(MAX_SLOTS);

  FDTState       state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [CW-1:0] target_q, target_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [SW-1:0] slots_q, slots_d;
  logic          last_bit_q, last_bit_d;
  logic          bad_q, bad_d;
  logic          tx_start_q, tx_start_d;
  logic          tx_active_q, tx_active_d;
  logic          window_missed_q, window_missed_d;
  logic          pause_end;
  logic          slot_decide;

  pause_edge_detect u_pause_edge (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pause_n_synchronised (pause_n_synchronised),
    .pause_end            (pause_end)
  );

  // Phase 0 is the tick before tx_start would be seen, since outputs are registered.
  assign slot_decide = (phase_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      counter_q       <= '0;
      target_q        <= TARGET_0;
      phase_q         <= '0;
      slots_q         <= '0;
      last_bit_q      <= 1'b0;
      bad_q           <= 1'b0;
      tx_start_q      <= 1'b0;
      tx_active_q     <= 1'b0;
      window_missed_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      counter_q       <= counter_d;
      target_q        <= target_d;
      phase_q         <= phase_d;
      slots_q         <= slots_d;
      last_bit_q      <= last_bit_d;
      bad_q           <= bad_d;
      tx_start_q      <= tx_start_d;
      tx_active_q     <= tx_active_d;
      window_missed_q <= window_missed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = (counter_q == CNT_MAX) ? counter_q : counter_q + 1'b1;
    target_d   = target_q;
    phase_d    = phase_q;
    slots_d    = slots_q;
    last_bit_d = last_bit_q;
    bad_d      = bad_q;

    if (state_q != TX) begin
      if (pause_end) counter_d = PRELOAD;
      if (rx_data_valid) last_bit_d = rx_data;
      else if (rx_soc)   last_bit_d = 1'b0;
      if (rx_eoc) target_d = last_bit_q ? TARGET_1 : TARGET_0;
    end

    case (state_q)
      IDLE: begin
        if (rx_soc) begin
          state_d = RX;
          bad_d   = 1'b0;
        end
      end
      RX: begin
        if (rx_error) bad_d = 1'b1;
        if (rx_eoc) begin
          state_d = bad_q ? IDLE : FDT_WAIT;
          bad_d   = 1'b0;
        end
      end
      FDT_WAIT: begin
        if (rx_soc) begin
          state_d = RX;
        end else if (counter_q == target_q - SLOT_LEAD) begin
          state_d = SLOT;
          phase_d = '0;
          slots_d = '0;
        end
      end
      SLOT: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == '1) slots_d = slots_q + 1'b1;
        if (rx_soc) begin
          state_d = RX;
        end else if (slot_decide) begin
          if (slots_q == SLOTS_LAST) state_d = IDLE;
          else if (tx_req)           state_d = TX;
        end
      end
      TX: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_start_d      = (state_q != TX) && (state_d == TX);
    tx_active_d     = (state_d == TX);
    window_missed_d = (state_q == SLOT) && slot_decide && !rx_soc && (slots_q == SLOTS_LAST);
  end

  assign tx_start      = tx_start_q;
  assign tx_active     = tx_active_q;
  assign window_missed = window_missed_q;

endmodule
`default_nettype wire
